// File: rtl/imem_loader_if.sv
// Host/CPU-facing bundle of the instruction store: byte-serial load handshake,
// status flags and the combinational fetch read port.
`timescale 1ns/1ps
interface imem_loader_if #(parameter int ADDR_W = 4);
  logic              load_en;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output load_en, byte_in, byte_valid, rd_addr,
    input  byte_ready, rd_data, cpu_hold, done, err
  );

  modport slave (
    input  load_en, byte_in, byte_valid, rd_addr,
    output byte_ready, rd_data, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Writable instruction store filled by a byte-serial loader: header (last index),
// hi/lo byte pairs, then an XOR checksum. CPU is held in reset during a session.
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HI, S_LO, S_CSUM, S_DONE, S_ERR} state_t;

  state_t            state, state_n;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] ptr, last;
  logic [7:0]        hi, xr;
  logic [TW-1:0]     tcnt;
  logic              done_q, err_q;
  logic              in_sess, acc, tmo, last_word, csum_ok;

  assign in_sess   = (state == S_HDR) || (state == S_HI) || (state == S_LO) || (state == S_CSUM);
  // Abort outranks accept: a byte offered while load_en drops is ignored.
  assign acc       = in_sess & bus.load_en & bus.byte_valid;
  assign tmo       = in_sess & bus.load_en & ~bus.byte_valid & (tcnt == TMAX);
  assign last_word = (ptr == last);
  assign csum_ok   = (bus.byte_in == xr);

  assign bus.byte_ready = in_sess;
  assign bus.cpu_hold   = in_sess;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rd_data    = mem[bus.rd_addr];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (bus.load_en) state_n = S_HDR;
      S_HDR, S_HI, S_LO, S_CSUM: begin
        if (!bus.load_en) state_n = S_IDLE;
        else if (acc) begin
          case (state)
            S_HDR:   state_n = S_HI;
            S_HI:    state_n = S_LO;
            S_LO:    state_n = last_word ? S_CSUM : S_HI;
            default: state_n = csum_ok ? S_DONE : S_ERR;
          endcase
        end else if (tmo) state_n = S_ERR;
      end
      S_DONE, S_ERR: if (!bus.load_en) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr    <= '0;
      last   <= '0;
      hi     <= '0;
      xr     <= '0;
      tcnt   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.load_en) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        ptr    <= '0;
        xr     <= '0;
        tcnt   <= '0;
      end
      if (in_sess && !bus.load_en) begin
        err_q <= 1'b1;
      end else if (acc) begin
        tcnt <= '0;
        case (state)
          S_HDR: begin
            last <= bus.byte_in[ADDR_W-1:0];
            xr   <= bus.byte_in;
          end
          S_HI: begin
            hi <= bus.byte_in;
            xr <= xr ^ bus.byte_in;
          end
          S_LO: begin
            mem[ptr] <= {hi, bus.byte_in};
            xr       <= xr ^ bus.byte_in;
            if (!last_word) ptr <= ptr + ADDR_W'(1);
          end
          default: begin
            if (csum_ok) done_q <= 1'b1;
            else         err_q  <= 1'b1;
          end
        endcase
      end else if (in_sess) begin
        if (tcnt == TMAX) err_q <= 1'b1;
        else              tcnt  <= tcnt + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int AW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();
  imem_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_mem [16];
  logic        exp_done, exp_err;
  logic [7:0]  pl [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, 32'(bus.done), 32'(d));
    chk({tag, "_err"},  32'(bus.err),  32'(e));
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus.rd_addr = 4'(a);
      tick;
      chk($sformatf("%s_mem%0d", tag, a), 32'(bus.rd_data), 32'(exp_mem[a]));
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    tick;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
  endtask

  task automatic do_reset;
    rst            = 1'b1;
    bus.load_en    = 1'b0;
    bus.byte_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  // Header, 2*(L+1) random payload bytes, then checksum (optionally corrupted).
  task automatic build(input logic [7:0] hdr, input bit bad);
    logic [7:0] x, b;
    int n;
    pl.delete();
    pl.push_back(hdr);
    x = hdr;
    n = 2 * (int'(hdr[3:0]) + 1);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      pl.push_back(b);
      x ^= b;
    end
    if (bad) x ^= 8'($urandom_range(255, 1));
    pl.push_back(x);
  endtask

  // Expected outcome comes from the whole stream: XOR of all but the last byte.
  task automatic model_stream;
    logic [7:0] h, x;
    int L;
    h = pl[0];
    L = int'(h[3:0]);
    x = 8'h00;
    for (int i = 0; i < pl.size() - 1; i++) x ^= pl[i];
    for (int k = 0; k <= L; k++) exp_mem[k] = {pl[1 + 2 * k], pl[2 + 2 * k]};
    exp_done = (x == pl[pl.size() - 1]);
    exp_err  = !exp_done;
  endtask

  task automatic run_stream(input string tag, input int gap);
    bus.load_en = 1'b1;
    tick;
    check_flags({tag, "_start"}, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < pl.size(); i++) begin
      send(pl[i], (gap < 0) ? int'($urandom_range(7, 0)) : gap);
      if (i == pl.size() - 2) chk({tag, "_hold_precsum"}, 32'(bus.cpu_hold), 32'd1);
    end
    model_stream();
    check_flags({tag, "_end"}, exp_done, exp_err, 1'b0);
    bus.load_en = 1'b0;
    tick;
    check_flags({tag, "_idle"}, exp_done, exp_err, 1'b0);
    check_mem(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] x;
    bus.load_en    = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.rd_addr    = '0;
    do_reset();
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    check_mem("rst");

    pl = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_stream("good2", 0);
    pl = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_stream("badcs", 0);
    pl = '{8'hF0, 8'h55, 8'hAA, 8'h0F};
    run_stream("hdrF0", 1);

    pl.delete();
    pl.push_back(8'h0F);
    x = 8'h0F;
    for (int i = 0; i < 32; i++) begin
      pl.push_back(8'(i));
      x ^= 8'(i);
    end
    pl.push_back(x);
    run_stream("full16", 0);

    build(8'h03, 1'b0);
    run_stream("gap7", TO - 1);

    // Timeout: header accepted, then no traffic.
    bus.load_en = 1'b1;
    tick;
    send(8'h03, 0);
    k = 0;
    while (!bus.err && k < 4 * TO) begin
      tick;
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'(TO));
    exp_done = 1'b0;
    exp_err  = 1'b1;
    check_flags("tmo", exp_done, exp_err, 1'b0);
    bus.load_en = 1'b0;
    tick;
    check_mem("tmo");

    // Abort after the hi byte of word 2.
    build(8'h05, 1'b0);
    bus.load_en = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) send(pl[i], int'($urandom_range(3, 0)));
    exp_mem[0] = {pl[1], pl[2]};
    exp_mem[1] = {pl[3], pl[4]};
    bus.load_en = 1'b0;
    tick;
    exp_done = 1'b0;
    exp_err  = 1'b1;
    check_flags("abort", exp_done, exp_err, 1'b0);
    check_mem("abort");

    repeat (12) begin
      build(8'($urandom), ($urandom_range(3, 0) == 0));
      run_stream("rnd", -1);
    end

    // Reset mid-session wipes outputs and memory.
    build(8'h0F, 1'b0);
    bus.load_en = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) send(pl[i], 0);
    do_reset();
    check_flags("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst_ready", 32'(bus.byte_ready), 32'd0);
    check_mem("midrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writable 16x16 instruction store plus a byte-serial loader FSM that fills it; it replaces the fixed instruction ROM and is the write side of the CPU's instruction-fetch read port.
A host streams a header byte, high/low instruction byte pairs and an XOR checksum over a valid/ready handshake.
The loader asserts cpu_hold for the whole session; the top level ORs cpu_hold into the CPU's reset.
The CPU fetches through the combinational read port.

Parameters:
ADDR_W, 4, instruction address width; depth = 2**ADDR_W words of 16 bits.
TIMEOUT_CYCLES, 1024, consecutive cycles without an accepted byte, inside a session, before the session aborts.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
load_en  input  1  session enable from host
byte_in  input  8  serial payload byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader can accept a byte this cycle
rd_addr  input  ADDR_W  CPU fetch word address
rd_data  output  16  instruction at rd_addr, combinational
cpu_hold  output  1  CPU must be held in reset
done  output  1  last session completed with good checksum (sticky)
err  output  1  last session failed: checksum, timeout or abort (sticky)

Behaviour:
- Reset: state=IDLE; byte_ready=0, cpu_hold=0, done=0, err=0; every memory word=16'h0000; word pointer=0; running XOR=0; timeout counter=0.
- Accept = byte_valid & byte_ready. byte_ready=1 only in HDR, HI, LO, CSUM.
- cpu_hold=1 in HDR, HI, LO, CSUM; 0 in IDLE, DONE, ERR.
- IDLE, load_en=1 -> HDR; same edge clears done, err, pointer, XOR, timeout counter.
- HDR, accept:
  - last index L = byte_in[3:0]; bits [7:4] ignored.
  - XOR = byte_in -> HI.
- HI, accept: latch hi byte; XOR ^= byte -> LO.
- LO, accept:
  - mem[pointer] <= {hi, byte_in} on the same edge; XOR ^= byte.
  - If pointer == L -> CSUM; else pointer+1 -> HI.
- CSUM, accept: byte == XOR -> DONE with done=1; else -> ERR with err=1.
  - Data already written is kept (no rollback).
- DONE/ERR: when load_en=0 -> IDLE; done/err remain set.
  - While load_en stays 1, remain in DONE/ERR; a new session needs load_en low then high.
- Abort: load_en=0 while in HDR/HI/LO/CSUM -> IDLE with err=1.
  - Words written so far are kept; a pending hi byte is discarded.
- Timeout counter:
  - Cleared on entry to HDR and on every accept.
  - Increments each cycle in a session state without an accept.
  - When the count reaches TIMEOUT_CYCLES-1 with no accept that cycle -> ERR, err=1.
  - The fault therefore appears after exactly TIMEOUT_CYCLES idle cycles.
- Priority on the same edge: rst > abort (load_en=0) > accept > timeout.
- Read port:
  - rd_data = mem[rd_addr], purely combinational.
  - A write to the same address becomes visible the cycle after the writing edge.
- Pointer never wraps past L; L=15 fills all 16 words.
- rst mid-session restores full reset state, including clearing the memory.

Test Plan:
- Reset then load_en=1, bytes 01,12,34,AB,CD,41 -> done=1, err=0; rd_addr=0 gives 1234, rd_addr=1 gives ABCD, rd_addr=2 gives 0000; cpu_hold high from the cycle after load_en until the checksum edge.
- Same stream with checksum 40 -> err=1, done=0; mem[0]=1234 and mem[1]=ABCD still present.
- Header F0 (L=0), bytes 55,AA, checksum F0^55^AA=0F -> done=1, mem[0]=55AA; header F0 with the upper nibble ignored.
- Header 0F followed by 32 bytes 00..1F in order, correct XOR checksum -> mem[k]={2k,2k+1} for k=0..15, done=1.
- TIMEOUT_CYCLES=8: send header, then hold byte_valid=0 -> err=1 exactly 8 cycles after header acceptance; byte_valid pulses with 7-cycle gaps complete the session normally.
- Drop load_en after the HI byte of word 2 -> IDLE, err=1, mem[2] unchanged.
- Pulse rst mid-session -> all outputs 0 and every word reads 0000.
